// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: pixel/line counters, phase tracking, sync decode
// and one-clock line/frame wrap pulses, all advancing on the pixel tick en.
module vga_scan_ctrl #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [1:0] h_state,
  output logic       line_end,
  output logic       frame_start
);

  localparam int unsigned CW    = 10;
  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOT - 1);
  localparam logic [CW-1:0] H_FRONT_AT = CW'(H_VIS);
  localparam logic [CW-1:0] H_SYNC_AT  = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] H_BACK_AT  = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOT - 1);
  localparam logic [CW-1:0] V_FRONT_AT = CW'(V_VIS);
  localparam logic [CW-1:0] V_SYNC_AT  = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] V_BACK_AT  = CW'(V_VIS + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_VIS   = 2'd0,
    PH_FRONT = 2'd1,
    PH_SYNC  = 2'd2,
    PH_BACK  = 2'd3
  } phase_e;

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  phase_e        h_state_q, h_state_d, v_state_q, v_state_d;
  logic          line_end_q, line_end_d;
  logic          frame_start_q, frame_start_d;
  logic          x_wrap, y_wrap;

  // Phase changes on the count value being entered, by exact boundary match.
  function automatic phase_e next_phase(input phase_e        cur,
                                        input logic [CW-1:0] nxt,
                                        input logic [CW-1:0] front_at,
                                        input logic [CW-1:0] sync_at,
                                        input logic [CW-1:0] back_at);
    next_phase = cur;
    if (nxt == '0)            next_phase = PH_VIS;
    else if (nxt == front_at) next_phase = PH_FRONT;
    else if (nxt == sync_at)  next_phase = PH_SYNC;
    else if (nxt == back_at)  next_phase = PH_BACK;
  endfunction

  assign x_wrap = (x_q == H_LAST);
  assign y_wrap = (y_q == V_LAST);

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    line_end_d    = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      x_d        = x_wrap ? '0 : x_q + CW'(1);
      h_state_d  = next_phase(h_state_q, x_d, H_FRONT_AT, H_SYNC_AT, H_BACK_AT);
      line_end_d = x_wrap;
      if (x_wrap) begin
        y_d           = y_wrap ? '0 : y_q + CW'(1);
        v_state_d     = next_phase(v_state_q, y_d, V_FRONT_AT, V_SYNC_AT, V_BACK_AT);
        frame_start_d = y_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      h_state_q     <= PH_VIS;
      v_state_q     <= PH_VIS;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Sync and blanking are pure decodes of the phase registers.
  assign x           = x_q;
  assign y           = y_q;
  assign h_state     = h_state_q;
  assign hsync       = (h_state_q != PH_SYNC);
  assign vsync       = (v_state_q != PH_SYNC);
  assign video_on    = (h_state_q == PH_VIS) && (v_state_q == PH_VIS);
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;

endmodule
